aes256_inv_key_expansion: RTL and testbench

Reverse AES-256 key schedule for the decryption datapath. It accepts the final 256-bit key state (round keys 13 and 14) and emits round keys 14, 13, …, 0 in descending order over a valid/ready handshake. Internally it walks the schedule backwards, 4 words per step. A single shared byte-wide SubBytes instance is used for one byte per cycle, matching the forward expander's area profile.

---
 rtl/aes256_inv_key_expansion.sv | 165 ++++++++++++++++
 tb/tb_aes256_inv_key_expansion.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes256_inv_key_expansion.sv
// Reverse AES-256 key schedule: emits round keys 14..0 from the final key state.
// Optional INV_KEY_ZEROIZE_EN clears the key window on the edge that accepts round 0.
module aes256_inv_key_expansion #(
  parameter int KEY_WIDTH = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [KEY_WIDTH-1:0]   key_in,
  output logic [KEY_WIDTH/2-1:0] round_key_o,
  output logic [3:0]             round_o,
  output logic                   round_key_valid,
  input  logic                   round_key_ready,
  output logic                   busy,
  output logic                   done
);

  typedef enum logic [1:0] {IDLE, OUT, SUB, FIX} state_t;

  // Forward S-box, row-major, byte 0x00 in the most significant position.
  localparam logic [2047:0] SBOX_TABLE = {
    256'h637c777bf26b6fc53001672bfed7ab76_ca82c97dfa5947f0add4a2af9ca472c0,
    256'hb7fd9326363ff7cc34a5e5f171d83115_04c723c31896059a071280e2eb27b275,
    256'h09832c1a1b6e5aa0523bd6b329e32f84_53d100ed20fcb15b6acbbe394a4c58cf,
    256'hd0efaafb434d338545f9027f503c9fa8_51a3408f929d38f5bcb6da2110fff3d2,
    256'hcd0c13ec5f974417c4a77e3d645d1973_60814fdc222a908846eeb814de5e0bdb,
    256'he0323a0a4906245cc2d3ac629195e479_e7c8376d8dd54ea96c56f4ea657aae08,
    256'hba78252e1ca6b4c6e8dd741f4bbd8b8a_703eb5664803f60e613557b986c11d9e,
    256'he1f8981169d98e949b1e87e9ce5528df_8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TABLE[(255 - int'(x)) * 8 +: 8];
  endfunction

  state_t      state, state_next;
  logic [31:0] win [8];
  logic [31:0] sub_word;
  logic [3:0]  r;
  logic [1:0]  cnt;

  logic        load_key, step_13, enter_sub, sub_en, commit;
  logic [3:0]  t;
  logic        t_even;
  logic [31:0] src_word;
  logic [7:0]  sbox_in, sbox_out, rcon;
  logic [31:0] temp_word;
  logic [31:0] n0, n1, n2, n3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next      = state;
    round_key_valid = 1'b0;
    done            = 1'b0;
    load_key        = 1'b0;
    step_13         = 1'b0;
    enter_sub       = 1'b0;
    sub_en          = 1'b0;
    commit          = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load_key   = 1'b1;
          state_next = OUT;
        end
      end
      OUT: begin
        round_key_valid = 1'b1;
        if (round_key_ready) begin
          if (r == 4'd14) begin
            step_13 = 1'b1;
          end else if (r == 4'd0) begin
            done       = 1'b1;
            state_next = IDLE;
          end else begin
            enter_sub  = 1'b1;
            state_next = SUB;
          end
        end
      end
      SUB: begin
        sub_en = 1'b1;
        if (cnt == 2'd3) state_next = FIX;
      end
      FIX: begin
        commit     = 1'b1;
        state_next = OUT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Rounds with even target index take RotWord+Rcon; odd ones take plain SubWord.
  always_comb begin
    t        = r - 4'd1;
    t_even   = ~t[0];
    src_word = t_even ? {win[3][23:0], win[3][31:24]} : win[3];
    case (cnt)
      2'd0:    sbox_in = src_word[31:24];
      2'd1:    sbox_in = src_word[23:16];
      2'd2:    sbox_in = src_word[15:8];
      default: sbox_in = src_word[7:0];
    endcase
    sbox_out  = sbox(sbox_in);
    rcon      = 8'h01 << t[3:1];
    temp_word = sub_word ^ (t_even ? {rcon, 24'h000000} : 32'h00000000);
    n0        = win[4] ^ temp_word;
    n1        = win[5] ^ win[4];
    n2        = win[6] ^ win[5];
    n3        = win[7] ^ win[6];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) win[i] <= '0;
      sub_word <= '0;
      r        <= '0;
      cnt      <= '0;
    end else begin
      if (load_key) begin
        for (int i = 0; i < 8; i++) win[i] <= key_in[KEY_WIDTH-1-32*i -: 32];
        r <= 4'd14;
      end else if (step_13) begin
        r <= 4'd13;
      end else if (enter_sub) begin
        cnt <= 2'd0;
      end else if (sub_en) begin
        case (cnt)
          2'd0:    sub_word[31:24] <= sbox_out;
          2'd1:    sub_word[23:16] <= sbox_out;
          2'd2:    sub_word[15:8]  <= sbox_out;
          default: sub_word[7:0]   <= sbox_out;
        endcase
        cnt <= cnt + 2'd1;
      end else if (commit) begin
        win[0] <= n0;
        win[1] <= n1;
        win[2] <= n2;
        win[3] <= n3;
        win[4] <= win[0];
        win[5] <= win[1];
        win[6] <= win[2];
        win[7] <= win[3];
        r      <= t;
      end
`ifdef INV_KEY_ZEROIZE_EN
      else if (done) begin
        for (int i = 0; i < 8; i++) win[i] <= '0;
        sub_word <= '0;
        r        <= '0;
      end
`endif
    end
  end

  assign round_key_o = (r == 4'd14) ? {win[4], win[5], win[6], win[7]}
                                    : {win[0], win[1], win[2], win[3]};
  assign round_o     = r;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_aes256_inv_key_expansion.sv
// Bench for aes256_inv_key_expansion: forward-expansion model with GF(2^8)-derived S-box,
// per-cycle timing/data model, directed FIPS-197 vector plus random keys.
module tb_aes256_inv_key_expansion;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [255:0] key_in;
  logic [127:0] round_key_o;
  logic [3:0]   round_o;
  logic         round_key_valid;
  logic         round_key_ready;
  logic         busy;
  logic         done;

  aes256_inv_key_expansion #(.KEY_WIDTH(256)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start           (start),
    .key_in          (key_in),
    .round_key_o     (round_key_o),
    .round_o         (round_o),
    .round_key_valid (round_key_valid),
    .round_key_ready (round_key_ready),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   sbox_tab [256];
  logic [31:0]  w [60];
  logic [127:0] exp_keys [15];
  bit           fips_run = 1'b0;

  // Model state, describing the cycle that follows each falling edge.
  bit           m_active = 1'b0;
  int           m_round = 0;
  int           m_gap = 0;
  int           seq_cycles = 0;
  logic [127:0] m_idle_key = '0;
  bit           prev_stall = 1'b0;
  logic [127:0] prev_key = '0;
  logic [3:0]   prev_round = '0;
  bit           pins_done = 1'b0;
  bit           exp_valid;

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_w(input logic [31:0] x);
    return {sbox_tab[x[31:24]], sbox_tab[x[23:16]], sbox_tab[x[15:8]], sbox_tab[x[7:0]]};
  endfunction

  // Forward FIPS-197 expansion; the DUT gets the last eight words.
  task automatic expand_key(input logic [255:0] key);
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
    for (int i = 8; i < 60; i++) begin
      tmp = w[i-1];
      if (i % 8 == 0) begin
        tmp = sub_w({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
        rc  = gmul(rc, 8'h02);
      end else if (i % 8 == 4) begin
        tmp = sub_w(tmp);
      end
      w[i] = w[i-8] ^ tmp;
    end
    for (int r = 0; r < 15; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    key_in = {w[52], w[53], w[54], w[55], w[56], w[57], w[58], w[59]};
  endtask

  task automatic check_output(input string name, input logic [127:0] act, input logic [127:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // The single compare process: checks every cycle, then advances the model.
  always @(negedge clk) begin
    if (!pins_done) begin
      pins_done = 1'b1;
      check_output("sbox_00", 128'(sbox_tab[8'h00]), 128'h63);
      check_output("sbox_53", 128'(sbox_tab[8'h53]), 128'hed);
      check_output("sbox_ff", 128'(sbox_tab[8'hff]), 128'h16);
    end
    if (!rst_n) begin
      check_output("reset_outputs", 128'({round_key_o, round_o, round_key_valid, busy, done}), 128'h0);
      m_active   = 1'b0;
      m_idle_key = '0;
      prev_stall = 1'b0;
    end else begin
      seq_cycles++;
      exp_valid = m_active && (m_gap == 0);
      check_output("valid", 128'(round_key_valid), 128'(exp_valid));
      check_output("busy", 128'(busy), 128'(m_active));
      check_output("done", 128'(done), 128'(exp_valid && round_key_ready && m_round == 0));
      if (exp_valid) begin
        check_output("round_key", round_key_o, exp_keys[m_round]);
        check_output("round_o", 128'(round_o), 128'(m_round));
        if (prev_stall) begin
          check_output("stall_key", round_key_o, prev_key);
          check_output("stall_round", 128'(round_o), 128'(prev_round));
        end
        if (fips_run && m_round == 14)
          check_output("fips_r14", round_key_o, 128'h24fc79ccbf0979e9371ac23c6d68de36);
        if (fips_run && m_round == 1)
          check_output("fips_r1", round_key_o, 128'h101112131415161718191a1b1c1d1e1f);
        if (fips_run && m_round == 0)
          check_output("fips_r0", round_key_o, 128'h000102030405060708090a0b0c0d0e0f);
      end else if (m_active) begin
        check_output("round_o_sub", 128'(round_o), 128'(m_round + 1));
      end else begin
        check_output("idle_round", 128'(round_o), 128'h0);
        check_output("idle_key", round_key_o, m_idle_key);
      end
      prev_stall = exp_valid && !round_key_ready;
      prev_key   = round_key_o;
      prev_round = round_o;
      if (m_active) begin
        if (exp_valid && round_key_ready) begin
          if (m_round == 0) begin
            m_active = 1'b0;
`ifdef INV_KEY_ZEROIZE_EN
            m_idle_key = '0;
`else
            m_idle_key = exp_keys[0];
`endif
            if (fips_run) check_output("fips_cycles", 128'(seq_cycles), 128'd80);
          end else if (m_round == 14) begin
            m_round = 13;
          end else begin
            m_round = m_round - 1;
            m_gap   = 5;
          end
        end else if (m_gap > 0) begin
          m_gap = m_gap - 1;
        end
      end else if (start) begin
        m_active   = 1'b1;
        m_round    = 14;
        m_gap      = 0;
        seq_cycles = 0;
      end
    end
  end

  task automatic apply_stimulus(input logic [255:0] key, input bit throttle, input bit noise,
                                input bit restart);
    int low_left = 0;
    int n = 0;
    bit hold = 1'b0;
    bit restart_left = restart;
    @(posedge clk); #1;
    expand_key(key);
    start           = 1'b1;
    round_key_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (m_active || hold) begin
      start = hold;
      hold  = 1'b0;
      if (throttle) begin
        if (low_left > 0) begin
          round_key_ready = 1'b0;
          low_left--;
        end else begin
          round_key_ready = 1'b1;
          if ($urandom_range(0, 2) == 0) low_left = $urandom_range(0, 7);
        end
      end else begin
        round_key_ready = 1'b1;
      end
      if (restart_left && m_active && m_gap == 0 && m_round == 0 && round_key_ready) begin
        start        = 1'b1;
        hold         = 1'b1;
        restart_left = 1'b0;
      end else if (noise && m_active && !(m_gap == 0 && m_round == 0) && $urandom_range(0, 4) == 0) begin
        start = 1'b1;
      end
      n++;
      if (n > 2000) begin
        $display("[TB] FAIL sequence_timeout: got %0d cycles, expected at most 2000", n);
        $fatal(1, "[TB] sequence did not complete");
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic reset_during_fix7(input logic [255:0] key);
    int n = 0;
    @(posedge clk); #1;
    expand_key(key);
    start           = 1'b1;
    round_key_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (!(m_active && m_round == 7 && m_gap == 1)) begin
      n++;
      if (n > 2000) begin
        $display("[TB] FAIL fix7_timeout: got %0d cycles, expected at most 2000", n);
        $fatal(1, "[TB] round 7 FIX not reached");
      end
      @(posedge clk); #1;
    end
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  function automatic logic [255:0] rand_key();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst_n           = 1'b0;
    start           = 1'b0;
    round_key_ready = 1'b0;
    key_in          = '0;
    build_sbox();
    for (int r = 0; r < 15; r++) exp_keys[r] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("[TB] FIPS-197 key, ready tied high");
    fips_run = 1'b1;
    apply_stimulus(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b0, 1'b0, 1'b0);
    fips_run = 1'b0;

    $display("[TB] random keys, unthrottled and throttled");
    for (int k = 0; k < 100; k++) apply_stimulus(rand_key(), k >= 60, 1'b0, 1'b0);

    $display("[TB] stray start pulses during OUT and SUB");
    for (int k = 0; k < 4; k++) apply_stimulus(rand_key(), k[0], 1'b1, 1'b0);

    $display("[TB] start in the done cycle");
    apply_stimulus(rand_key(), 1'b0, 1'b0, 1'b1);

    $display("[TB] reset during FIX of round 7, then clean sequence");
    reset_during_fix7(rand_key());
    apply_stimulus(rand_key(), 1'b0, 1'b0, 1'b0);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
